unit_scan_controller: RTL and testbench

Sequences a full unit-clause scan over the clause row store. One row at a time, it reads the static literal row and the dynamic falsified-mask row through a one-cycle-latency read port and evaluates the row. Each unit clause's forced literal is emitted on a valid/ready stream toward the implication queue. The scan aborts with a conflict report if a clause has every literal falsified. It sits between the propagation top-level FSM, which issues start and abort, and the clause row memory.

---
 rtl/unit_scan_controller_if.sv | 31 +++
 rtl/unit_scan_controller.sv | 159 +++++++++++++++
 tb/tb_unit_scan_controller.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/unit_scan_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : unit_scan_controller_if
// Description : Clause row read port plus forced-literal valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface unit_scan_controller_if #(
    parameter int NUM_ROWS     = 16,
    parameter int COLS_PER_ROW = 4,
    parameter int LIT_WIDTH    = 6
);
    logic                              row_rd_en;
    logic [$clog2(NUM_ROWS)-1:0]       row_addr;
    logic [COLS_PER_ROW*LIT_WIDTH-1:0] static_row;
    logic [COLS_PER_ROW-1:0]           dynamic_row;
    logic                              unit_valid;
    logic [LIT_WIDTH-1:0]              unit_literal;
    logic [$clog2(NUM_ROWS)-1:0]       unit_row;
    logic                              unit_ready;

    modport master (
        output row_rd_en, row_addr, unit_valid, unit_literal, unit_row,
        input  static_row, dynamic_row, unit_ready
    );

    modport slave (
        input  row_rd_en, row_addr, unit_valid, unit_literal, unit_row,
        output static_row, dynamic_row, unit_ready
    );
endinterface
`default_nettype wire

// File: rtl/unit_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : unit_scan_controller
// Description : Scans every clause row once, emitting unit literals and
//               stopping early on the first fully falsified clause.
// Revision    : 1.0 - initial release
// ============================================================================
module unit_scan_controller #(
    parameter int NUM_ROWS     = 16,
    parameter int COLS_PER_ROW = 4,
    parameter int LIT_WIDTH    = 6
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    input  wire logic                          start,
    input  wire logic                          abort,
    output logic                               busy,
    output logic                               done,
    output logic                               conflict,
    output logic [$clog2(NUM_ROWS)-1:0]        conflict_row,
    output logic [$clog2(NUM_ROWS+1)-1:0]      unit_count,
    unit_scan_controller_if.master             bus
);
    localparam int ROW_W  = $clog2(NUM_ROWS);
    localparam int CNT_W  = $clog2(NUM_ROWS+1);
    localparam int CAND_W = $clog2(COLS_PER_ROW+1);
    localparam logic [ROW_W-1:0] c_LAST_ROW = ROW_W'(NUM_ROWS-1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EVAL = 3'd2,
        S_EMIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ROW_W-1:0]      r_ptr;
    logic [ROW_W-1:0]      r_conflict_row;
    logic [ROW_W-1:0]      r_unit_row;
    logic [CNT_W-1:0]      r_unit_count;
    logic                  r_conflict;
    logic [LIT_WIDTH-1:0]  r_unit_literal;

    logic                  w_any_lit;
    logic [CAND_W-1:0]     w_cand_cnt;
    logic [LIT_WIDTH-1:0]  w_cand_lit;
    logic                  w_is_unit;
    logic                  w_is_conflict;
    logic                  w_last;
    logic                  w_xfer;

    // Row classification; only meaningful in EVAL when read data is valid.
    always_comb begin
        w_any_lit  = 1'b0;
        w_cand_cnt = '0;
        w_cand_lit = '0;
        for (int i = 0; i < COLS_PER_ROW; i++) begin
            if (bus.static_row[i*LIT_WIDTH +: LIT_WIDTH] != '0) begin
                w_any_lit = 1'b1;
                if (!bus.dynamic_row[i]) begin
                    w_cand_cnt = w_cand_cnt + 1'b1;
                    w_cand_lit = bus.static_row[i*LIT_WIDTH +: LIT_WIDTH];
                end
            end
        end
    end

    assign w_is_unit     = (w_cand_cnt == CAND_W'(1));
    assign w_is_conflict = w_any_lit && (w_cand_cnt == '0);
    assign w_last        = (r_ptr == c_LAST_ROW);
    assign w_xfer        = bus.unit_valid && bus.unit_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_next = S_READ;
            S_READ: w_state_next = S_EVAL;
            S_EVAL: begin
                if (w_is_unit)          w_state_next = S_EMIT;
                else if (w_is_conflict) w_state_next = S_DONE;
                else if (w_last)        w_state_next = S_DONE;
                else                    w_state_next = S_READ;
            end
            S_EMIT: if (w_xfer) w_state_next = w_last ? S_DONE : S_READ;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        // Abort outranks everything outside IDLE, including a same-cycle transfer.
        if (abort && (r_state != S_IDLE)) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr          <= '0;
            r_conflict     <= 1'b0;
            r_conflict_row <= '0;
            r_unit_count   <= '0;
            r_unit_literal <= '0;
            r_unit_row     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ptr          <= '0;
                        r_conflict     <= 1'b0;
                        r_conflict_row <= '0;
                        r_unit_count   <= '0;
                    end
                end
                S_EVAL: begin
                    if (!abort) begin
                        if (w_is_unit) begin
                            r_unit_literal <= w_cand_lit;
                            r_unit_row     <= r_ptr;
                        end else if (w_is_conflict) begin
                            r_conflict     <= 1'b1;
                            r_conflict_row <= r_ptr;
                        end else if (!w_last) begin
                            r_ptr <= r_ptr + 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (w_xfer && !abort) begin
                        r_unit_count <= r_unit_count + 1'b1;
                        if (!w_last) begin
                            r_ptr <= r_ptr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy             = (r_state != S_IDLE);
    assign done             = (r_state == S_DONE);
    assign conflict         = r_conflict;
    assign conflict_row     = r_conflict_row;
    assign unit_count       = r_unit_count;
    assign bus.row_rd_en    = (r_state == S_READ);
    assign bus.row_addr     = r_ptr;
    assign bus.unit_valid   = (r_state == S_EMIT);
    assign bus.unit_literal = r_unit_literal;
    assign bus.unit_row     = r_unit_row;
endmodule
`default_nettype wire

// File: tb/tb_unit_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_unit_scan_controller
// Description : Directed scoreboard bench for unit_scan_controller (4 rows).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unit_scan_controller;
    localparam int NR = 4;
    localparam int CP = 4;
    localparam int LW = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic       conflict;
    logic [1:0] conflict_row;
    logic [2:0] unit_count;

    unit_scan_controller_if #(.NUM_ROWS(NR), .COLS_PER_ROW(CP), .LIT_WIDTH(LW)) ifc ();

    unit_scan_controller #(.NUM_ROWS(NR), .COLS_PER_ROW(CP), .LIT_WIDTH(LW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .conflict     (conflict),
        .conflict_row (conflict_row),
        .unit_count   (unit_count),
        .bus          (ifc.master)
    );

    always #5 clk = ~clk;

    logic [23:0] static_mem [NR];
    logic [3:0]  dyn_mem    [NR];

    // One-cycle-latency row memory
    always @(posedge clk) begin
        if (ifc.row_rd_en) begin
            ifc.static_row  <= static_mem[ifc.row_addr];
            ifc.dynamic_row <= dyn_mem[ifc.row_addr];
        end
    end

    typedef struct packed {logic [5:0] lit; logic [1:0] row;} unit_t;
    typedef struct packed {logic c; logic [1:0] crow; logic [2:0] cnt;} done_t;

    unit_t      exp_units[$];
    done_t      exp_done[$];
    logic [1:0] exp_reads[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] mk(input int s0, input int s1, input int s2, input int s3);
        return {6'(s3), 6'(s2), 6'(s1), 6'(s0)};
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents something.
    logic  prev_valid = 1'b0;
    unit_t prev_unit  = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (ifc.row_rd_en) begin
                if (exp_reads.size() == 0) chk("unexpected_read", 32'(ifc.row_addr), 32'hFFFF);
                else chk("read_addr", 32'(ifc.row_addr), 32'(exp_reads.pop_front()));
            end
            if (ifc.unit_valid) begin
                if (prev_valid) chk("unit_stable", 32'({ifc.unit_literal, ifc.unit_row}), 32'(prev_unit));
                if (ifc.unit_ready && !abort) begin
                    if (exp_units.size() == 0) chk("unexpected_unit", 32'({ifc.unit_literal, ifc.unit_row}), 32'hFFFF);
                    else chk("unit_lit_row", 32'({ifc.unit_literal, ifc.unit_row}), 32'(exp_units.pop_front()));
                    prev_valid <= 1'b0;
                end else begin
                    prev_valid <= 1'b1;
                    prev_unit  <= {ifc.unit_literal, ifc.unit_row};
                end
            end else begin
                prev_valid <= 1'b0;
            end
            if (done) begin
                if (exp_done.size() == 0) chk("unexpected_done", 32'({conflict, conflict_row, unit_count}), 32'hFFFF);
                else chk("done_status", 32'({conflict, conflict_row, unit_count}), 32'(exp_done.pop_front()));
            end
        end
    end

    // Runs one pass from start; cycle 1 is the first cycle after start is sampled.
    task automatic run_pass(input int stall, input int abort_unit, output int done_cyc,
                            output int end_cyc, output int last_rd, output int valid_cycles,
                            output logic [31:0] rd_mask);
        int   cyc;
        int   emits;
        logic was_valid;
        bit   fin;
        done_cyc = -1; end_cyc = -1; last_rd = -1; valid_cycles = 0; rd_mask = '0;
        emits = 0; was_valid = 1'b0; fin = 1'b0;
        ifc.unit_ready = (stall == 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!fin && cyc < 200) begin
            abort = 1'b0;
            if (ifc.row_rd_en) begin
                if (cyc < 32) rd_mask[cyc] = 1'b1;
                last_rd = cyc;
            end
            if (ifc.unit_valid) begin
                if (!was_valid) emits++;
                valid_cycles++;
                if (abort_unit == emits) begin
                    abort = 1'b1;
                    ifc.unit_ready = 1'b1;
                end else begin
                    ifc.unit_ready = (valid_cycles > stall);
                end
            end
            was_valid = ifc.unit_valid;
            if (done) begin
                done_cyc = cyc;
                fin = 1'b1;
            end else if (!busy) begin
                fin = 1'b1;
            end
            if (fin) end_cyc = cyc;
            else begin
                tick();
                cyc++;
            end
        end
        chk("pass_terminated", 32'(fin), 32'd1);
        abort = 1'b0;
        tick();
    endtask

    initial begin
        int          dc, ec, lr, vc;
        logic [31:0] rm;
        rst = 1'b1; start = 1'b0; abort = 1'b0; ifc.unit_ready = 1'b0;
        for (int i = 0; i < NR; i++) begin static_mem[i] = '0; dyn_mem[i] = '0; end
        tick(); tick();
        rst = 1'b0;
        chk("reset_outputs", 32'({busy, done, conflict, ifc.unit_valid, ifc.row_rd_en, ifc.row_addr,
                                  conflict_row, unit_count, ifc.unit_literal, ifc.unit_row}), 32'd0);

        // All rows empty
        for (int i = 0; i < NR; i++) exp_reads.push_back(2'(i));
        exp_done.push_back('{c: 1'b0, crow: 2'd0, cnt: 3'd0});
        run_pass(0, 0, dc, ec, lr, vc, rm);
        chk("empty_done_cycle", 32'(dc), 32'd9);
        chk("empty_read_cycles", rm, 32'h0000_00AA);

        // Single unit at row 2, ready immediately, then with a 4-cycle stall
        for (int i = 0; i < NR; i++) begin static_mem[i] = mk(1, 2, 0, 0); dyn_mem[i] = 4'b0000; end
        static_mem[2] = mk(0, 0, 5, 3); dyn_mem[2] = 4'b1000;
        for (int i = 0; i < NR; i++) exp_reads.push_back(2'(i));
        exp_units.push_back('{lit: 6'd5, row: 2'd2});
        exp_done.push_back('{c: 1'b0, crow: 2'd0, cnt: 3'd1});
        run_pass(0, 0, dc, ec, lr, vc, rm);
        chk("unit_done_cycle", 32'(dc), 32'd10);
        chk("unit_valid_cycles", 32'(vc), 32'd1);

        for (int i = 0; i < NR; i++) exp_reads.push_back(2'(i));
        exp_units.push_back('{lit: 6'd5, row: 2'd2});
        exp_done.push_back('{c: 1'b0, crow: 2'd0, cnt: 3'd1});
        run_pass(4, 0, dc, ec, lr, vc, rm);
        chk("stall_valid_cycles", 32'(vc), 32'd5);
        chk("stall_done_cycle", 32'(dc), 32'd14);
        chk("stall_last_read_gap", 32'(dc - lr), 32'd2);

        // Conflict at row 1; rows 2 and 3 never read
        for (int i = 0; i < NR; i++) begin static_mem[i] = mk(1, 2, 0, 0); dyn_mem[i] = 4'b0000; end
        static_mem[1] = mk(7, 9, 0, 0); dyn_mem[1] = 4'b0011;
        exp_reads.push_back(2'd0); exp_reads.push_back(2'd1);
        exp_done.push_back('{c: 1'b1, crow: 2'd1, cnt: 3'd0});
        run_pass(0, 0, dc, ec, lr, vc, rm);
        chk("conflict_done_cycle", 32'(dc), 32'd5);
        chk("conflict_read_cycles", rm, 32'h0000_000A);
        chk("conflict_held", 32'({conflict, conflict_row}), 32'({1'b1, 2'd1}));

        // Units at rows 0 and 2; abort during the second EMIT with ready high
        for (int i = 0; i < NR; i++) begin static_mem[i] = mk(1, 2, 0, 0); dyn_mem[i] = 4'b0000; end
        static_mem[0] = mk(7, 0, 0, 0);
        static_mem[2] = mk(0, 0, 5, 3); dyn_mem[2] = 4'b1000;
        exp_reads.push_back(2'd0); exp_reads.push_back(2'd1); exp_reads.push_back(2'd2);
        exp_units.push_back('{lit: 6'd7, row: 2'd0});
        run_pass(0, 2, dc, ec, lr, vc, rm);
        chk("abort_no_done", 32'(dc), 32'hFFFF_FFFF);
        chk("abort_idle_cycle", 32'(ec), 32'd9);
        chk("abort_outputs", 32'({busy, ifc.unit_valid, unit_count}), 32'({1'b0, 1'b0, 3'd1}));

        // Reset during EVAL of row 1, then a full rescan
        exp_reads.push_back(2'd0); exp_reads.push_back(2'd1);
        exp_units.push_back('{lit: 6'd7, row: 2'd0});
        ifc.unit_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("pre_reset_count", 32'({busy, unit_count, ifc.row_addr}), 32'({1'b1, 3'd1, 2'd1}));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midpass_reset_outputs", 32'({busy, done, conflict, ifc.unit_valid, ifc.row_rd_en, ifc.row_addr,
                                          conflict_row, unit_count, ifc.unit_literal, ifc.unit_row}), 32'd0);
        for (int i = 0; i < NR; i++) exp_reads.push_back(2'(i));
        exp_units.push_back('{lit: 6'd7, row: 2'd0});
        exp_units.push_back('{lit: 6'd5, row: 2'd2});
        exp_done.push_back('{c: 1'b0, crow: 2'd0, cnt: 3'd2});
        run_pass(0, 0, dc, ec, lr, vc, rm);
        chk("rescan_done_cycle", 32'(dc), 32'd11);

        repeat (3) tick();
        chk("reads_drained", 32'(exp_reads.size()), 32'd0);
        chk("units_drained", 32'(exp_units.size()), 32'd0);
        chk("dones_drained", 32'(exp_done.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
